// File: rtl/sysid_regs_pkg.sv
// sysid_regs shared constants: word map, CAPS layout, unmapped value.
// Imported by sysid_regs and sysid_regs_rdpipe.
package sysid_regs_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
    localparam logic [2:0] ADDR_CAPS      = 3'd5;

    localparam int CAPS_UPTIME_BIT  = 0;
    localparam int CAPS_LATENCY_LSB = 4;
    localparam int CAPS_TICKDIV_LSB = 16;

    localparam logic [31:0] UNMAPPED_VALUE = 32'h0;

    function automatic logic [31:0] caps_word(
        input int   tick_div,
        input int   latency,
        input logic uptime_present
    );
        logic [31:0] w;
        w = '0;
        w[CAPS_TICKDIV_LSB +: 16] = 16'(tick_div);
        w[CAPS_LATENCY_LSB +: 4]  = 4'(latency);
        w[CAPS_UPTIME_BIT]        = uptime_present;
        return w;
    endfunction

endpackage

// File: rtl/sysid_regs_rdpipe.sv
// sysid_regs read-return delay line: LATENCY stages of data and valid.
// Reset empties every stage so in-flight reads never return.
module sysid_regs_rdpipe
    import sysid_regs_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [WIDTH-1:0] sample,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic [LATENCY-1:0] vld;
    logic [WIDTH-1:0]   dat [LATENCY];

    // Shift the sampled word and its valid flag one stage per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld[0] <= accept;
            dat[0] <= sample;
            for (int k = 1; k < LATENCY; k++) begin
                vld[k] <= vld[k-1];
                dat[k] <= dat[k-1];
            end
        end
    end

    assign valid = vld[LATENCY-1];
    assign data  = dat[LATENCY-1];

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: system ID / timestamp / uptime / scratch register slave.
// Uptime logic is built only when SYSID_REGS_UPTIME_EN is defined.
module sysid_regs
    import sysid_regs_pkg::*;
#(
    parameter logic [31:0] ID_VALUE        = 32'd364094772,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'd1426599870,
    parameter int          READ_LATENCY    = 1,
    parameter int          TICK_DIV        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [31:0] scratch;
    logic [31:0] up_lo;
    logic [31:0] up_hi;
    logic [31:0] rd_word;
    logic        wr_scratch;

`ifdef SYSID_REGS_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
    localparam int   PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescale;
    logic [63:0]   uptime;
    logic [31:0]   shadow;
    logic          wrap;

    assign wrap = (prescale == PW'(TICK_DIV - 1));

    // Prescaler wrap advances the free-running 64-bit uptime counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            uptime   <= '0;
        end else if (wrap) begin
            prescale <= '0;
            uptime   <= uptime + 64'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Low-word read freezes the high word so the pair reads coherently.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (read && address == ADDR_UPTIME_LO) begin
            shadow <= uptime[63:32];
        end
    end

    assign up_lo = uptime[31:0];
    assign up_hi = shadow;
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign up_lo = UNMAPPED_VALUE;
    assign up_hi = UNMAPPED_VALUE;
`endif

    localparam logic [31:0] CAPS_VALUE =
        caps_word(TICK_DIV, READ_LATENCY, UPTIME_PRESENT);

    // A simultaneous read wins; the write is dropped.
    assign wr_scratch = write && !read && (address == ADDR_SCRATCH);

    // Byte-lane merge into the only writable register.
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= '0;
        end else if (wr_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Select the word to sample at acceptance.
    always_comb begin
        rd_word = UNMAPPED_VALUE;
        case (address)
            ADDR_ID:        rd_word = ID_VALUE;
            ADDR_TIMESTAMP: rd_word = TIMESTAMP_VALUE;
            ADDR_UPTIME_LO: rd_word = up_lo;
            ADDR_UPTIME_HI: rd_word = up_hi;
            ADDR_SCRATCH:   rd_word = scratch;
            ADDR_CAPS:      rd_word = CAPS_VALUE;
            default:        rd_word = UNMAPPED_VALUE;
        endcase
    end

    sysid_regs_rdpipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (32)
    ) u_rdpipe (
        .clk    (clk),
        .reset  (reset),
        .accept (read),
        .sample (rd_word),
        .valid  (readdatavalid),
        .data   (readdata)
    );

endmodule

// File: tb/tb_sysid_regs.sv
// Bench for sysid_regs: two instances (latency 1 / div 1, latency 3 / div 4)
// checked against a scoreboard fed by a register-map model.
module tb_sysid_regs;

`ifdef SYSID_REGS_UPTIME_EN
    localparam logic UP = 1'b1;
`else
    localparam logic UP = 1'b0;
`endif

    localparam logic [31:0] ID_W = 32'd364094772;
    localparam logic [31:0] TS_W = 32'd1426599870;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [2:0]  addr  [2];
    logic [31:0] wd    [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        rdv   [2];

    always #5 clk = ~clk;

    sysid_regs #(.READ_LATENCY(1), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]),
        .write(wr[0]), .writedata(wd[0]), .byteenable(be[0]),
        .readdata(rdata[0]), .readdatavalid(rdv[0])
    );

    sysid_regs #(.READ_LATENCY(3), .TICK_DIV(4)) dut_b (
        .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]),
        .write(wr[1]), .writedata(wd[1]), .byteenable(be[1]),
        .readdata(rdata[1]), .readdatavalid(rdv[1])
    );

    typedef struct {
        longint      due;
        logic [31:0] d;
        string       tag;
    } exp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp;
        string       tag;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[13];

    int errors = 0;
    int checks = 0;
    int pulses_b = 0;
    longint cyc = 0;
    longint unsigned n[2];
    logic [31:0] m_scr[2];
    logic [31:0] m_shd[2];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic longint unsigned tdv(input int i);
        return (i == 0) ? 64'd1 : 64'd4;
    endfunction

    function automatic logic [31:0] caps_of(input int i);
        return (i == 0) ? (32'h0001_0010 | 32'(UP))
                        : (32'h0004_0030 | 32'(UP));
    endfunction

    task automatic model_read(input int i, input logic [2:0] a,
                              output logic [31:0] d);
        longint unsigned up;
        up = n[i] / tdv(i);
        case (a)
            3'd0: d = ID_W;
            3'd1: d = TS_W;
            3'd2: begin
                d = UP ? up[31:0] : 32'h0;
                if (UP) m_shd[i] = up[63:32];
            end
            3'd3: d = UP ? m_shd[i] : 32'h0;
            3'd4: d = m_scr[i];
            3'd5: d = caps_of(i);
            default: d = 32'h0;
        endcase
    endtask

    task automatic chk(input int i);
        exp_t e;
        bit   has;
        has = 0;
        if (i == 0 && qa.size() > 0 && qa[0].due == cyc) begin
            has = 1;
            e = qa.pop_front();
        end
        if (i == 1 && qb.size() > 0 && qb[0].due == cyc) begin
            has = 1;
            e = qb.pop_front();
        end
        if (i == 1 && rdv[1] === 1'b1) pulses_b++;
        if (rdv[i] === 1'b1) begin
            checks++;
            if (!has) begin
                errors++;
                $display("FAIL rdv_unexpected inst=%0d cyc=%0d got valid=1 want 0",
                         i, cyc);
            end else if (rdata[i] !== e.d) begin
                errors++;
                $display("FAIL %s inst=%0d cyc=%0d got %h want %h",
                         e.tag, i, cyc, rdata[i], e.d);
            end
        end else if (has) begin
            checks++;
            errors++;
            $display("FAIL %s_missing inst=%0d cyc=%0d got valid=%b want 1",
                     e.tag, i, cyc, rdv[i]);
        end
    endtask

    // One clock: advance model time, score returns, drop read/write strobes.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                n[i] = 0;
                m_scr[i] = 32'h0;
                m_shd[i] = 32'h0;
                if (i == 0) qa.delete();
                else qb.delete();
            end else begin
                n[i]++;
            end
        end
        chk(0);
        chk(1);
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
        end
    endtask

    task automatic set(input int i, input logic rs, input logic r,
                       input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input string tag, input bit use_exp,
                       input logic [31:0] exp);
        exp_t        e;
        logic [31:0] md;
        rst[i]  = rs;
        rd[i]   = r;
        wr[i]   = w;
        addr[i] = a;
        wd[i]   = d;
        be[i]   = b;
        if (!rs && r) begin
            model_read(i, a, md);
            e.due = cyc + lat(i);
            e.d   = use_exp ? exp : md;
            e.tag = tag;
            if (i == 0) qa.push_back(e);
            else qb.push_back(e);
        end else if (!rs && w && a == 3'd4) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) m_scr[i][8*k +: 8] = d[8*k +: 8];
            end
        end
    endtask

    task automatic do_reset(input int i);
        tick();
        set(i, 1, 0, 0, 0, 0, 0, "", 0, 0);
        tick();
        set(i, 1, 0, 0, 0, 0, 0, "", 0, 0);
        tick();
        checks++;
        if (rdata[i] !== 32'h0 || rdv[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst=%0d got data=%h valid=%b want 0/0",
                     i, rdata[i], rdv[i]);
        end
        set(i, 0, 0, 0, 0, 0, 0, "", 0, 0);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = '0; wd[i] = '0; be[i] = '0;
            n[i] = 0; m_scr[i] = '0; m_shd[i] = '0;
        end

        tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        4'h0, ID_W,          "id"};
        tbl[1]  = '{1'b1, 1'b0, 3'd1, 32'h0,        4'h0, TS_W,          "timestamp"};
        tbl[2]  = '{1'b0, 1'b1, 3'd4, 32'hA5A5A5A5, 4'hF, 32'h0,         "wr_full"};
        tbl[3]  = '{1'b0, 1'b1, 3'd4, 32'h00000000, 4'h5, 32'h0,         "wr_lanes"};
        tbl[4]  = '{1'b1, 1'b0, 3'd4, 32'h0,        4'h0, 32'hA500A500,  "scratch_be"};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 32'h0,         "wr_ro"};
        tbl[6]  = '{1'b1, 1'b0, 3'd0, 32'h0,        4'h0, ID_W,          "id_ro"};
        tbl[7]  = '{1'b0, 1'b1, 3'd5, 32'h0,        4'hF, 32'h0,         "wr_caps"};
        tbl[8]  = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, caps_of(0),    "caps_a"};
        tbl[9]  = '{1'b1, 1'b0, 3'd6, 32'h0,        4'h0, 32'h0,         "unmapped6"};
        tbl[10] = '{1'b1, 1'b0, 3'd7, 32'h0,        4'h0, 32'h0,         "unmapped7"};
        tbl[11] = '{1'b1, 1'b1, 3'd4, 32'h1,        4'hF, 32'hA500A500,  "rd_wins"};
        tbl[12] = '{1'b1, 1'b0, 3'd4, 32'h0,        4'h0, 32'hA500A500,  "scratch_kept"};

        do_reset(0);
        do_reset(1);

        // Back-to-back table traffic on the latency-1 instance.
        for (int k = 0; k < 13; k++) begin
            tick();
            set(0, 0, tbl[k].r, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].b,
                tbl[k].tag, 1, tbl[k].exp);
        end
        tick();
        tick();

        do_reset(0);
        tick();
        set(0, 0, 1, 0, 3'd4, 0, 0, "scratch_reset", 1, 32'h0);
        tick();
        tick();

`ifdef SYSID_REGS_UPTIME_EN
        tick();
        force dut_a.uptime = 64'h0000_0001_FFFF_FFFF;
        set(0, 0, 1, 0, 3'd2, 0, 0, "uptime_lo_forced", 1, 32'hFFFFFFFF);
        tick();
        release dut_a.uptime;
        tick();
        tick();
        tick();
        tick();
        set(0, 0, 1, 0, 3'd3, 0, 0, "shadow_hi", 1, 32'h00000001);
        tick();
        tick();
        do_reset(0);
`endif

        // Tick-divider check on the latency-3 / div-4 instance.
        do_reset(1);
        repeat (40) tick();
        set(1, 0, 1, 0, 3'd2, 0, 0, "uptime_div4", 1, UP ? 32'd10 : 32'h0);
        tick();
        set(1, 0, 1, 0, 3'd5, 0, 0, "caps_b", 1, caps_of(1));
        repeat (5) tick();

        // Reset during a burst drops the in-flight read.
        set(1, 0, 1, 0, 3'd0, 0, 0, "dropped", 1, ID_W);
        tick();
        set(1, 1, 1, 0, 3'd1, 0, 0, "", 0, 0);
        tick();
        snap = pulses_b;
        set(1, 0, 1, 0, 3'd4, 0, 0, "post_rst_rd3", 1, 32'h0);
        tick();
        set(1, 0, 1, 0, 3'd5, 0, 0, "post_rst_rd4", 1, caps_of(1));
        repeat (6) tick();
        checks++;
        if (pulses_b - snap != 2) begin
            errors++;
            $display("FAIL burst_pulses got %0d want 2", pulses_b - snap);
        end

        set(1, 0, 1, 1, 3'd4, 32'h1, 4'hF, "rw_b", 1, 32'h0);
        tick();
        set(1, 0, 1, 0, 3'd4, 0, 0, "scratch_unchanged", 1, 32'h0);
        repeat (5) tick();

        // Randomized traffic on both instances against the model.
        repeat (400) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                set(i, ($urandom_range(0, 63) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0),
                    3'($urandom_range(0, 7)),
                    $urandom,
                    4'($urandom_range(0, 15)),
                    "rand", 0, 0);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) set(i, 0, 0, 0, 0, 0, 0, "", 0, 0);
        repeat (8) tick();

        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d want 0/0",
                     qa.size(), qb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
